// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, default timing
// parameters and frame layout used by the host transmitter and receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE,
    FINISH
  } ps2_tx_state_e;

  localparam int CLK_INHIBIT_CYCLES_DEF = 5000;
  localparam int TIMEOUT_CYCLES_DEF     = 750000;
  localparam int FILTER_LEN_DEF         = 8;
  localparam int FRAME_W                = 10;

  // Frame bit 0 leaves first: eight data bits LSB first, odd parity, stop.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus FILTER_LEN-sample level filter for one PS/2 line,
// with a registered pulse on each accepted 1->0 transition.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic fall
);

  logic [1:0]            sync;
  logic [FILTER_LEN-1:0] hist;
  logic [FILTER_LEN-1:0] hist_nxt;

  assign hist_nxt = {hist[FILTER_LEN-2:0], sync[1]};

  // Level only moves once the whole sample window agrees.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= 2'b11;
      hist  <= '1;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], line_in};
      hist <= hist_nxt;
      fall <= 1'b0;
      if (&hist_nxt) begin
        level <= 1'b1;
      end else if (~|hist_nxt) begin
        level <= 1'b0;
        fall  <= level;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts out one command frame on device clock falls and checks the ACK bit.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_INHIBIT_CYCLES = CLK_INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES     = TIMEOUT_CYCLES_DEF,
  parameter int FILTER_LEN         = FILTER_LEN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  inout  wire        ps2_clk,
  inout  wire        ps2_data
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > CLK_INHIBIT_CYCLES) ?
                           TIMEOUT_CYCLES : CLK_INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  ps2_tx_state_e      state, state_nxt;
  logic [FRAME_W-1:0] frame, frame_nxt;
  logic [3:0]         bit_cnt, bit_cnt_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               err, err_nxt;
  logic               c_oe_nxt, d_oe_nxt;
  logic               c_level, c_fall;
  logic               d_level, d_fall_unused;
  logic               inhibit_end, timeout;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk     (clk),
    .reset   (reset),
    .line_in (ps2c_in),
    .level   (c_level),
    .fall    (c_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk     (clk),
    .reset   (reset),
    .line_in (ps2d_in),
    .level   (d_level),
    .fall    (d_fall_unused)
  );

  assign inhibit_end = (cnt == CNT_W'(CLK_INHIBIT_CYCLES - 1));
  assign timeout     = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt   = state;
    frame_nxt   = frame;
    bit_cnt_nxt = bit_cnt;
    cnt_nxt     = cnt;
    err_nxt     = err;
    c_oe_nxt    = 1'b0;
    d_oe_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_start) begin
          state_nxt   = INHIBIT;
          frame_nxt   = make_frame(tx_data);
          bit_cnt_nxt = '0;
          cnt_nxt     = '0;
          err_nxt     = 1'b0;
          c_oe_nxt    = 1'b1;
        end
      end
      INHIBIT: begin
        c_oe_nxt = 1'b1;
        cnt_nxt  = cnt + 1'b1;
        if (inhibit_end) begin
          state_nxt = RTS;
          c_oe_nxt  = 1'b0;
          d_oe_nxt  = 1'b1;
          cnt_nxt   = '0;
        end
      end
      RTS: begin
        d_oe_nxt = 1'b1;
        cnt_nxt  = cnt + 1'b1;
        if (c_fall) begin
          state_nxt   = SHIFT;
          d_oe_nxt    = ~frame[0];
          bit_cnt_nxt = 4'd1;
          cnt_nxt     = '0;
        end else if (timeout) begin
          state_nxt = FINISH;
          d_oe_nxt  = 1'b0;
          err_nxt   = 1'b1;
        end
      end
      SHIFT: begin
        d_oe_nxt = ps2d_oe;
        cnt_nxt  = cnt + 1'b1;
        if (c_fall) begin
          d_oe_nxt    = ~frame[bit_cnt];
          bit_cnt_nxt = bit_cnt + 4'd1;
          cnt_nxt     = '0;
          if (bit_cnt == 4'(FRAME_W - 1)) state_nxt = ACK;
        end else if (timeout) begin
          state_nxt = FINISH;
          d_oe_nxt  = 1'b0;
          err_nxt   = 1'b1;
        end
      end
      ACK: begin
        cnt_nxt = cnt + 1'b1;
        if (c_fall) begin
          state_nxt = WAIT_IDLE;
          err_nxt   = d_level;
          cnt_nxt   = '0;
        end else if (timeout) begin
          state_nxt = FINISH;
          err_nxt   = 1'b1;
        end
      end
      WAIT_IDLE: begin
        cnt_nxt = cnt + 1'b1;
        if (c_level && d_level) begin
          state_nxt = FINISH;
        end else if (timeout) begin
          state_nxt = FINISH;
          err_nxt   = 1'b1;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      cnt     <= '0;
      err     <= 1'b0;
      ps2c_oe <= 1'b0;
      ps2d_oe <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      cnt     <= cnt_nxt;
      err     <= err_nxt;
      ps2c_oe <= c_oe_nxt;
      ps2d_oe <= d_oe_nxt;
    end
  end

  always_ff @(posedge clk) begin
    frame <= frame_nxt;
  end

  assign tx_busy  = (state != IDLE);
  assign tx_done  = (state == FINISH);
  assign tx_error = (state == FINISH) && err;

  // Open-drain pins: only ever pull low, otherwise float for the pull-up.
  assign ps2_clk  = ps2c_oe ? 1'b0 : 1'bz;
  assign ps2_data = ps2d_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 keyboard clocks frames out of the
// host and the captured bits are compared with a frame built from the byte.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 400;
  localparam int FLEN = 4;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_c = 1'b1;
  logic       dev_d = 1'b1;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_error;
  wire        ps2_clk_pin, ps2_data_pin;

  int   n_vec = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  logic last_err = 1'b0;

  assign ps2c_in = dev_c & ~ps2c_oe;
  assign ps2d_in = dev_d & ~ps2d_oe;

  ps2_host_tx #(
    .CLK_INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES     (TMO),
    .FILTER_LEN         (FLEN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .ps2c_in  (ps2c_in),
    .ps2d_in  (ps2d_in),
    .ps2c_oe  (ps2c_oe),
    .ps2d_oe  (ps2d_oe),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_error (tx_error),
    .ps2_clk  (ps2_clk_pin),
    .ps2_data (ps2_data_pin)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done === 1'b1) begin
      done_cnt++;
      last_err = tx_error;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference: data LSB first, parity makes the nine bits odd, stop is 1.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d};
  endfunction

  task automatic start_tx(input logic [7:0] d);
    tick();
    chk("busy_low_before_start", 16'(tx_busy), 16'(0));
    tx_data  = d;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    chk("busy_after_start", 16'(tx_busy), 16'(1));
  endtask

  task automatic device_run(input bit ack, input int nfalls, input int inject_at,
                            input int reset_at, output logic [9:0] got);
    int w;
    got = '0;
    w = 0;
    while (ps2c_oe !== 1'b1 && w < 50) begin tick(); w++; end
    w = 0;
    while (ps2c_oe === 1'b1 && w < 1000) begin tick(); w++; end
    chk("inhibit_len", 16'(w), 16'(INH));
    chk("start_bit", 16'(ps2d_in), 16'(0));
    repeat (HALF) tick();
    for (int k = 1; k <= nfalls; k++) begin
      dev_c = 1'b0;
      if (k == reset_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dev_c = 1'b1;
        chk("rst_clk_released", 16'(ps2c_oe), 16'(0));
        chk("rst_data_released", 16'(ps2d_oe), 16'(0));
        chk("rst_busy_low", 16'(tx_busy), 16'(0));
        return;
      end else if (k == inject_at) begin
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        repeat (HALF - 1) tick();
      end else begin
        repeat (HALF) tick();
      end
      dev_c = 1'b1;
      repeat (HALF) tick();
      if (k <= 10) got[k-1] = ps2d_in;
      if (k == 10 && ack) dev_d = 1'b0;
      if (k == 11) dev_d = 1'b1;
    end
  endtask

  task automatic wait_done(input int snap, input int limit, output int waited);
    waited = 0;
    while (done_cnt == snap && waited < limit) begin tick(); waited++; end
    chk("done_seen", 16'(done_cnt != snap), 16'(1));
  endtask

  task automatic send_frame(input logic [7:0] d, input bit ack, output logic [9:0] got);
    int snap, w;
    snap = done_cnt;
    start_tx(d);
    device_run(ack, 11, -1, -1, got);
    wait_done(snap, 200, w);
    chk("frame_bits", 16'(got), 16'(model_frame(d)));
    chk("tx_error", 16'(last_err), 16'(!ack));
    chk("end_clk_released", 16'(ps2c_oe), 16'(0));
    chk("end_data_released", 16'(ps2d_oe), 16'(0));
  endtask

  initial begin
    logic [9:0] got;
    logic [7:0] d;
    bit         ack;
    int         snap, w;

    // Reset with a coincident start request that must be dropped.
    reset    = 1'b1;
    tx_start = 1'b1;
    tx_data  = 8'h55;
    repeat (3) tick();
    reset    = 1'b0;
    tx_start = 1'b0;
    tick();
    chk("rst_ps2c_oe", 16'(ps2c_oe), 16'(0));
    chk("rst_ps2d_oe", 16'(ps2d_oe), 16'(0));
    chk("rst_tx_busy", 16'(tx_busy), 16'(0));
    chk("rst_tx_done", 16'(tx_done), 16'(0));
    chk("rst_tx_error", 16'(tx_error), 16'(0));
    repeat (5) tick();
    chk("start_with_reset_dropped", 16'(tx_busy), 16'(0));

    // 0xED with ACK, bits compared against the literal expected frame.
    send_frame(8'hED, 1'b1, got);
    chk("ed_bits", 16'(got), 16'h03ED);

    // Back-to-back 0x00 then 0x01.
    snap = done_cnt;
    send_frame(8'h00, 1'b1, got);
    chk("parity_00", 16'(got[8]), 16'(1));
    send_frame(8'h01, 1'b1, got);
    chk("parity_01", 16'(got[8]), 16'(0));
    chk("two_done_pulses", 16'(done_cnt - snap), 16'(2));

    // Device never acknowledges.
    send_frame(8'h3A, 1'b0, got);

    // Device stops clocking after bit 3.
    snap = done_cnt;
    start_tx(8'hA5);
    device_run(1'b1, 4, -1, -1, got);
    chk("tmo_partial_bits", 16'(got[3:0]), 16'(4'h5));
    chk("tmo_no_early_done", 16'(done_cnt), 16'(snap));
    wait_done(snap, 600, w);
    chk("tmo_window", 16'((w + 2*HALF) >= TMO && (w + 2*HALF) <= TMO + 20), 16'(1));
    chk("tmo_error", 16'(last_err), 16'(1));
    chk("tmo_clk_released", 16'(ps2c_oe), 16'(0));
    chk("tmo_data_released", 16'(ps2d_oe), 16'(0));

    // Start request with 0xFF during SHIFT must not disturb the frame.
    snap = done_cnt;
    start_tx(8'h3C);
    device_run(1'b1, 11, 4, -1, got);
    wait_done(snap, 200, w);
    chk("inject_frame_bits", 16'(got), 16'(model_frame(8'h3C)));
    chk("inject_error", 16'(last_err), 16'(0));
    repeat (100) tick();
    chk("inject_single_done", 16'(done_cnt - snap), 16'(1));

    // Reset mid-SHIFT, then a clean 0xF4.
    snap = done_cnt;
    start_tx(8'h99);
    device_run(1'b1, 11, -1, 5, got);
    repeat (100) tick();
    chk("rst_no_done", 16'(done_cnt - snap), 16'(0));
    send_frame(8'hF4, 1'b1, got);

    // Randomized bytes and ACK behaviour.
    for (int i = 0; i < 4; i++) begin
      d   = 8'($urandom);
      ack = 1'($urandom_range(0, 1));
      send_frame(d, ack, got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_INHIBIT_CYCLES, 5000, clock-low hold time before the start bit (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, 750000, maximum clk cycles between device clock falling edges (15 ms).
REQ-003 Parameter FILTER_LEN, 8, number of equal consecutive samples required to accept a PS/2 line level.
REQ-004 clk  in  1  single system clock (CLOCK_50 domain).
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 tx_data  in  8  command byte to send to the keyboard.
REQ-007 tx_start  in  1  one-cycle request to send tx_data.
REQ-008 ps2c_in  in  1  raw PS/2 clock pin level (asynchronous).
REQ-009 ps2d_in  in  1  raw PS/2 data pin level (asynchronous).
REQ-010 ps2c_oe  out  1  1 = drive the PS/2 clock low; 0 = release it (open drain).
REQ-011 ps2d_oe  out  1  1 = drive the PS/2 data line low; 0 = release it.
REQ-012 tx_busy  out  1  transfer in progress; the PS/2 receiver ignores the lines while this is high.
REQ-013 tx_done  out  1  one-cycle pulse at the end of every accepted transfer.
REQ-014 tx_error  out  1  valid with tx_done; 1 = timeout or missing ACK.

Function
REQ-015 ps2c_in and ps2d_in SHALL each pass through a 2-flop synchronizer and a FILTER_LEN-sample level filter; a device clock falling edge (fall) is a filtered 1->0 transition.
REQ-016 The state machine SHALL have the states IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE and FINISH.
REQ-017 IDLE: when tx_start=1, latch the frame {stop=1, parity=~^tx_data, tx_data} (bit 0 = tx_data[0]) and go to INHIBIT; tx_busy is high from the next cycle.
REQ-018 tx_start SHALL be ignored in every state other than IDLE; tx_data is sampled only on the accepting cycle.
REQ-019 INHIBIT: ps2c_oe=1 and ps2d_oe=0 for exactly CLK_INHIBIT_CYCLES cycles, then go to RTS.
REQ-020 RTS: ps2c_oe=0 and ps2d_oe=1 (start bit); the first fall SHALL output frame bit 0 and enter SHIFT with bit_cnt=1.
REQ-021 SHIFT: on each fall, output frame bit bit_cnt (ps2d_oe = ~bit) and increment bit_cnt; bit_cnt increments on fall only.
REQ-022 The fall that outputs bit 9 (stop, released) SHALL enter ACK; ps2d_oe stays 0 from then on.
REQ-023 ACK: on the next fall, sample the filtered data line; 0 means ACK, 1 sets err; go to WAIT_IDLE.
REQ-024 WAIT_IDLE: wait until filtered clock and data are both 1, then go to FINISH.
REQ-025 FINISH: assert tx_done=1 with tx_error=err for one cycle, then go to IDLE with tx_busy=0.
REQ-026 Timeout: in RTS, SHIFT, ACK and WAIT_IDLE, a cycle counter resets on each fall and on state entry.
REQ-027 Timeout: when the counter reaches TIMEOUT_CYCLES-1, release both lines, set err=1 and go to FINISH.
REQ-028 ps2c_oe and ps2d_oe SHALL be registered outputs; no combinational path runs from the inputs to them.
REQ-029 Line-drive summary: ps2c_oe=1 only in INHIBIT; ps2d_oe is nonzero only in RTS and SHIFT.

Reset
REQ-030 When reset=1 on a clk edge: state=IDLE; ps2c_oe, ps2d_oe, tx_busy, tx_done and tx_error are 0; bit_cnt, counters and err are 0; synchronizers and filters are set to 1.
REQ-031 Reset mid-transfer SHALL release both lines on the next edge and SHALL NOT produce tx_done.
REQ-032 A tx_start coincident with reset SHALL be dropped.

Structure
REQ-033 The shared package ps2_pkg SHALL hold the state encoding, the default CLK_INHIBIT_CYCLES, TIMEOUT_CYCLES and FILTER_LEN, and the frame width constant (10).
REQ-034 The synchronizer, filter and fall detector SHALL be the single sub-module ps2_line_filter, reusable by the PS/2 receiver.
REQ-035 The top level SHALL convert ps2c_oe and ps2d_oe to inout pins as pin = oe ? 0 : Z.

Verification (CLK_INHIBIT_CYCLES=20, TIMEOUT_CYCLES=400, FILTER_LEN=4; device model clocks at 40-cycle period)
REQ-036 Send 0xED with device ACK -> clock held low 20 cycles; data bits observed 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done=1 with tx_error=0.
REQ-037 Send 0x00 then 0x01 back to back -> parity 1 then 0; two tx_done pulses; tx_busy low for at least 1 cycle between them.
REQ-038 Device leaves data high at the ACK clock -> tx_done=1 with tx_error=1; both lines released.
REQ-039 Device stops clocking after bit 3 -> after 400 idle cycles, tx_done=1 with tx_error=1, ps2c_oe=0 and ps2d_oe=0.
REQ-040 tx_start pulsed during SHIFT with tx_data=0xFF -> ignored; the frame in flight is unchanged and only one tx_done occurs.
REQ-041 reset asserted mid-SHIFT -> next cycle ps2c_oe=0, ps2d_oe=0, tx_busy=0; no tx_done; a following send of 0xF4 completes with tx_error=0.
